// File: rtl/fu_wb_queue.sv
// Writeback queue on the controller side of a functional unit: records destination
// PRNs at issue, queues FU results with those PRNs, and drains them to the PRF/ROB.
module fu_wb_queue #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int DEPTH        = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [INST_ID_BITS-1:0]                inst_id,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  out_prn,
  input  logic                                   inst_valid,
  output logic                                   issue_ready,
  input  logic [MAX_OPERANDS-1:0][63:0]          fu_out_data,
  input  logic [MAX_OPERANDS-1:0]                fu_out_data_valid,
  input  logic [INST_ID_BITS-1:0]                fu_out_inst_id,
  input  logic                                   fu_out_valid,
  output logic                                   wb_valid,
  input  logic                                   wb_ready,
  output logic [INST_ID_BITS-1:0]                wb_inst_id,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  wb_prn,
  output logic [MAX_OPERANDS-1:0][63:0]          wb_data,
  output logic [MAX_OPERANDS-1:0]                wb_data_valid,
  output logic                                   overflow
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn_tab [2**INST_ID_BITS];

  logic [INST_ID_BITS-1:0]               id_mem   [DEPTH];
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn_mem  [DEPTH];
  logic [MAX_OPERANDS-1:0][63:0]         data_mem [DEPTH];
  logic [MAX_OPERANDS-1:0]               dv_mem   [DEPTH];

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, inflight;
  logic          full, push, pop;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] cap_prn;

  // Handshake: an entry transfers on a clk edge where wb_valid && wb_ready; while
  // wb_valid is high and wb_ready low the head payload is held unchanged.
  assign full    = (count == CW'(DEPTH));
  assign wb_valid = (count != '0);
  assign pop     = wb_valid && wb_ready;
  assign push    = fu_out_valid && (!full || pop);

  // Zero-latency completion: the table is written on this same edge, so forward.
  assign cap_prn = (inst_valid && (inst_id == fu_out_inst_id)) ? out_prn
                                                               : prn_tab[fu_out_inst_id];

  assign issue_ready = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(DEPTH);

  assign wb_inst_id    = wb_valid ? id_mem[head]   : '0;
  assign wb_prn        = wb_valid ? prn_mem[head]  : '0;
  assign wb_data       = wb_valid ? data_mem[head] : '0;
  assign wb_data_valid = wb_valid ? dv_mem[head]   : '0;

  always_ff @(posedge clk) begin
    if (inst_valid) prn_tab[inst_id] <= out_prn;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[tail]   <= fu_out_inst_id;
      prn_mem[tail]  <= cap_prn;
      data_mem[tail] <= fu_out_data;
      dv_mem[tail]   <= fu_out_data_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Credits saturate at both ends; a result with no credit outstanding is an error.
      case ({inst_valid, fu_out_valid})
        2'b10:   if (inflight != CW'(DEPTH)) inflight <= inflight + CW'(1);
        2'b01:   if (inflight != '0)         inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (fu_out_valid && ((full && !pop) || (inflight == '0 && !inst_valid)))
        overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fu_wb_queue.sv
// Bench for fu_wb_queue: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based reference model.
module tb_fu_wb_queue;
  localparam int IB = 6;
  localparam int PB = 6;
  localparam int MO = 3;
  localparam int D  = 4;
  localparam int EW = IB + MO*PB + MO*64 + MO;

  logic clk = 1'b0;
  logic rst;
  logic [IB-1:0]         inst_id;
  logic [MO-1:0][PB-1:0] out_prn;
  logic                  inst_valid;
  logic                  issue_ready;
  logic [MO-1:0][63:0]   fu_out_data;
  logic [MO-1:0]         fu_out_data_valid;
  logic [IB-1:0]         fu_out_inst_id;
  logic                  fu_out_valid;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [IB-1:0]         wb_inst_id;
  logic [MO-1:0][PB-1:0] wb_prn;
  logic [MO-1:0][63:0]   wb_data;
  logic [MO-1:0]         wb_data_valid;
  logic                  overflow;

  fu_wb_queue #(.INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .inst_id(inst_id), .out_prn(out_prn), .inst_valid(inst_valid),
    .issue_ready(issue_ready), .fu_out_data(fu_out_data),
    .fu_out_data_valid(fu_out_data_valid), .fu_out_inst_id(fu_out_inst_id),
    .fu_out_valid(fu_out_valid), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_inst_id(wb_inst_id), .wb_prn(wb_prn), .wb_data(wb_data),
    .wb_data_valid(wb_data_valid), .overflow(overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0]         exp_q[$];
  logic [MO-1:0][PB-1:0] tab [2**IB];
  int                    m_infl = 0;
  bit                    m_ovf  = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    bit m_full, m_pop, m_push;
    logic [MO-1:0][PB-1:0] p;
    if (rst) begin
      exp_q.delete();
      m_infl = 0;
      m_ovf  = 1'b0;
    end else begin
      m_full = (exp_q.size() == D);
      m_pop  = (exp_q.size() != 0) && wb_ready;
      m_push = fu_out_valid && (!m_full || m_pop);
      p = (inst_valid && inst_id == fu_out_inst_id) ? out_prn : tab[fu_out_inst_id];
      if (fu_out_valid && ((m_full && !m_pop) || (m_infl == 0 && !inst_valid))) m_ovf = 1'b1;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({fu_out_inst_id, p, fu_out_data, fu_out_data_valid});
      if (inst_valid) tab[inst_id] = out_prn;
      if (inst_valid && !fu_out_valid && m_infl < D) m_infl++;
      else if (!inst_valid && fu_out_valid && m_infl > 0) m_infl--;
    end
  end

  // ---------------- scoreboard compare, mid-cycle ----------------
  always @(negedge clk) begin : compare
    logic [EW-1:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("wb_valid", wb_valid, exp_q.size() != 0);
    chk("issue_ready", issue_ready, (exp_q.size() + m_infl) < D);
    chk("overflow", overflow, m_ovf);
    chk("wb_inst_id", wb_inst_id, h[EW-1 -: IB]);
    chk("wb_prn", wb_prn, h[EW-IB-1 -: MO*PB]);
    chk("wb_data", wb_data, h[MO*64+MO-1 -: MO*64]);
    chk("wb_data_valid", wb_data_valid, h[MO-1:0]);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_valid   = 1'b0;
    fu_out_valid = 1'b0;
  endtask

  task automatic rand_payload();
    for (int s = 0; s < MO; s++) fu_out_data[s] = {$urandom, $urandom};
    fu_out_data_valid = MO'($urandom_range(0, 2**MO - 1));
  endtask

  logic [IB-1:0] pend[$];
  logic [IB-1:0] next_id;
  bit            byp;

  initial begin
    rst = 1'b1; wb_ready = 1'b0; inst_id = '0; out_prn = '0; fu_out_inst_id = '0;
    fu_out_data = '0; fu_out_data_valid = '0;
    idle();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_wb_prn", wb_prn, 0);
    chk("rst_wb_data", wb_data, 0);

    // Single op: id 5, PRNs 7/8/9 in slots 0/1/2, result two cycles later.
    wb_ready = 1'b1;
    inst_valid = 1'b1; inst_id = 6'd5; out_prn = {6'd9, 6'd8, 6'd7};
    tick(); idle(); tick();
    fu_out_valid = 1'b1; fu_out_inst_id = 6'd5;
    fu_out_data = {64'h33, 64'h22, 64'h11}; fu_out_data_valid = 3'b101;
    tick(); idle();
    chk("single_wb_valid", wb_valid, 1);
    chk("single_wb_prn", wb_prn, {6'd9, 6'd8, 6'd7});
    chk("single_wb_data", wb_data, {64'h33, 64'h22, 64'h11});
    chk("single_wb_dv", wb_data_valid, 3'b101);
    chk("single_wb_id", wb_inst_id, 6'd5);
    tick();
    chk("single_drained", wb_valid, 0);

    // Bypass: table holds 60/61/62 for id 3, simultaneous issue+result uses 1/2/3.
    inst_valid = 1'b1; inst_id = 6'd3; out_prn = {6'd62, 6'd61, 6'd60};
    tick(); idle();
    fu_out_valid = 1'b1; fu_out_inst_id = 6'd3; rand_payload();
    tick(); idle(); tick();
    inst_valid = 1'b1; inst_id = 6'd3; out_prn = {6'd3, 6'd2, 6'd1};
    fu_out_valid = 1'b1; fu_out_inst_id = 6'd3; rand_payload();
    tick(); idle();
    chk("bypass_wb_prn", wb_prn, {6'd3, 6'd2, 6'd1});
    tick();

    // Backpressure: four issues fill the credits, four results fill the queue.
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inst_valid = 1'b1; inst_id = IB'(10 + i); out_prn = {PB'(i), PB'(i + 20), PB'(i + 40)};
      tick();
    end
    idle();
    chk("full_issue_ready", issue_ready, 0);
    for (int i = 0; i < 4; i++) begin
      fu_out_valid = 1'b1; fu_out_inst_id = IB'(10 + i); rand_payload();
      tick();
    end
    idle();
    chk("full_head_id", wb_inst_id, 6'd10);
    chk("full_wb_prn", wb_prn, {6'd0, 6'd20, 6'd40});
    tick();
    chk("full_head_held", wb_inst_id, 6'd10);

    // Push and pop together while full; issue while not ready is still accepted.
    inst_valid = 1'b1; inst_id = 6'd14; out_prn = {6'd14, 6'd15, 6'd16};
    tick(); idle();
    fu_out_valid = 1'b1; fu_out_inst_id = 6'd14; wb_ready = 1'b1; rand_payload();
    tick(); idle(); wb_ready = 1'b0;
    chk("pushpop_head_id", wb_inst_id, 6'd11);
    chk("pushpop_overflow", overflow, 0);

    // Result into a full queue with no pop is dropped and flagged.
    fu_out_valid = 1'b1; fu_out_inst_id = 6'd14; rand_payload();
    tick(); idle();
    chk("ovf_set", overflow, 1);
    chk("ovf_head_id", wb_inst_id, 6'd11);
    tick();
    chk("ovf_sticky", overflow, 1);

    // Drain in order; one pop frees a credit.
    wb_ready = 1'b1;
    tick();
    chk("drain_issue_ready", issue_ready, 1);
    chk("drain_head_id", wb_inst_id, 6'd12);
    repeat (3) tick();
    chk("drain_empty", wb_valid, 0);

    // Spurious result after reset: no credit outstanding.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    wb_ready = 1'b0;
    fu_out_valid = 1'b1; fu_out_inst_id = 6'd5; rand_payload();
    tick(); idle();
    chk("spurious_ovf", overflow, 1);
    chk("spurious_prn", wb_prn, {6'd9, 6'd8, 6'd7});
    fu_out_valid = 1'b1; fu_out_inst_id = 6'd3; rand_payload();
    tick(); idle();

    // Asynchronous reset mid-cycle with two entries queued.
    #2 rst = 1'b1;
    #1;
    chk("async_wb_valid", wb_valid, 0);
    chk("async_issue_ready", issue_ready, 1);
    chk("async_overflow", overflow, 0);
    chk("async_wb_data", wb_data, 0);
    tick(); rst = 1'b0; tick();

    // Random traffic: the issuer honours the model's credit count.
    next_id = '0;
    for (int n = 0; n < 3000; n++) begin
      idle(); byp = 1'b0;
      wb_ready = ($urandom_range(0, 3) != 0);
      if (((exp_q.size() + m_infl) < D) && $urandom_range(0, 2) != 0) begin
        inst_valid = 1'b1; inst_id = next_id; next_id = next_id + IB'(1);
        for (int s = 0; s < MO; s++) out_prn[s] = PB'($urandom_range(0, 2**PB - 1));
      end
      if (pend.size() != 0 && $urandom_range(0, 1) == 1) begin
        fu_out_valid = 1'b1; fu_out_inst_id = pend.pop_front();
      end else if (inst_valid && $urandom_range(0, 3) == 0) begin
        fu_out_valid = 1'b1; fu_out_inst_id = inst_id; byp = 1'b1;
      end
      if (inst_valid && !byp) pend.push_back(inst_id);
      rand_payload();
      tick();
    end
    idle(); wb_ready = 1'b1;
    for (int n = 0; n < 40 && pend.size() != 0; n++) begin
      idle();
      fu_out_valid = 1'b1; fu_out_inst_id = pend.pop_front(); rand_payload();
      tick();
    end
    idle();
    repeat (8) tick();
    chk("final_empty", wb_valid, 0);
    chk("final_overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fu_wb_queue.md
Name: fu_wb_queue

Overview:
- Sits on the controller side of a functional unit's `fu_if`, opposite the FU.
- Snoops the issue fields (inst_id, out_prn, inst_valid) and records the destination PRNs per instruction.
- Captures each FU result, looks up its PRNs and queues it in a FIFO.
- Drains the FIFO to the PRF/ROB writeback path with a valid/ready handshake.
- Generates issue_ready (credit-based) so the issuer never overflows the queue, since the FU itself has no backpressure.

Parameters:
- INST_ID_BITS, 6, width of instruction ID; PRN table has 2^INST_ID_BITS entries.
- PRN_BITS, 6, physical register number width.
- MAX_OPERANDS, 3, destination slots per instruction.
- DEPTH, 4, result FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- inst_id  in  INST_ID_BITS  ID of instruction issued this cycle.
- out_prn  in  PRN_BITS x MAX_OPERANDS  destination PRNs of the issued instruction.
- inst_valid  in  1  issue strobe into the FU.
- issue_ready  out  1  a new issue is permitted this cycle.
- fu_out_data  in  64 x MAX_OPERANDS  FU result data.
- fu_out_data_valid  in  1 x MAX_OPERANDS  per-slot write enable from FU.
- fu_out_inst_id  in  INST_ID_BITS  ID of completing instruction.
- fu_out_valid  in  1  FU result strobe.
- wb_valid  out  1  head entry available.
- wb_ready  in  1  consumer accepts head entry.
- wb_inst_id  out  INST_ID_BITS  head instruction ID (ROB completion).
- wb_prn  out  PRN_BITS x MAX_OPERANDS  head destination PRNs.
- wb_data  out  64 x MAX_OPERANDS  head data.
- wb_data_valid  out  1 x MAX_OPERANDS  head per-slot write enables.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (async, rst=1): FIFO head/tail/count=0, inflight=0, overflow=0, wb_valid=0, issue_ready=1. wb_* payload outputs read 0. The PRN table is not reset.
- PRN table:
  - On clk edge with inst_valid=1: table[inst_id] <= out_prn.
  - Overwriting a live ID is the issuer's responsibility.
- Result capture:
  - On clk edge with fu_out_valid=1 and FIFO not full (or full with a pop this cycle), push one entry: fu_out_inst_id, fu_out_data, fu_out_data_valid, and PRNs.
  - PRNs come from table[fu_out_inst_id].
  - Bypass: if inst_valid=1 and inst_id==fu_out_inst_id in the same cycle, the PRNs come from out_prn (zero-latency FU).
- Drain:
  - wb_valid = (count!=0). wb_* present the head entry combinationally from storage.
  - Pop on clk edge when wb_valid && wb_ready.
  - Payload is held stable while wb_valid=1 and wb_ready=0.
- Push and pop in the same cycle: both occur, count unchanged. Legal when full. Not legal when empty: there is no FIFO bypass, and an empty queue produces no pop.
- Latency: a result accepted at edge N appears on wb_* after edge N (wb_valid high in cycle N+1).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- inflight counter (0..DEPTH): +1 on inst_valid, -1 on fu_out_valid; simultaneous events leave it unchanged.
- issue_ready = (count + inflight) < DEPTH. Combinational from registered state only; no dependence on this cycle's wb_ready.
- overflow:
  - Set and held until reset on fu_out_valid when FIFO full and no pop. That result is dropped and the FIFO is unchanged.
  - Also set on fu_out_valid with inflight=0 and no simultaneous inst_valid; inflight then stays 0 (saturates).
- Issue while issue_ready=0: accepted into the table and inflight incremented, saturating at DEPTH. Not flagged.
- Reset mid-operation: all queued and inflight state is discarded immediately, without waiting for a clock edge.

Test Plan:
- Single op: issue id=5 with PRNs {7,8,9}; 2 cycles later result id=5, data {0x11,0x22,0x33}, valid {1,0,1}, wb_ready=1 -> one cycle of wb_valid with wb_prn {7,8,9}, wb_data {0x11,0x22,0x33}, wb_data_valid {1,0,1}, wb_inst_id=5.
- Bypass: inst_valid and fu_out_valid in the same cycle, both id=3, out_prn {1,2,3} -> wb_prn={1,2,3} even though the table previously held {60,61,62} for id=3.
- Backpressure/full: DEPTH=4, wb_ready=0, issue 4 ops -> issue_ready drops to 0 after the 4th issue. All 4 results queue, with wb payload held on the first. Raise wb_ready -> 4 pops in order; issue_ready returns to 1 after the first pop.
- Simultaneous push/pop at full: count=4, fu_out_valid and wb_ready both high -> count stays 4, head advances, overflow=0.
- Overflow: force fu_out_valid with FIFO full and wb_ready=0 -> overflow=1 and sticky, entry dropped, count=4. A spurious result with inflight=0 also sets overflow.
- Async reset: assert rst mid-cycle with 2 entries queued -> wb_valid=0, issue_ready=1, overflow=0 immediately, before the next clk edge.
